alp_controller: RTL and testbench

- Control unit for the arithmetic-logic processor datapath.
- Samples an opcode on a start strobe, then drives every datapath control input in sequence: selects, enables, resets, ALU op, Q-register mode and flag updates.
- Consumes the datapath status flags.
- Single-cycle ops finish in one execute cycle; unsigned multiply runs as a shift-add sequence driven by an iteration counter.

---
 rtl/alp_controller_if.sv | 50 +++++
 rtl/alp_controller.sv | 199 +++++++++++++++++++
 tb/tb_alp_controller.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alp_controller_if.sv
// Control/status bundle between the ALP controller and its datapath.
// The controller plays the slave side: it takes the op request and status
// flags, and drives every datapath control line.
interface alp_controller_if;
  logic       i_start;
  logic [2:0] i_op;
  logic       i_Q0;
  logic       i_acc_sign;
  logic       i_r0_sign;
  logic       i_r1_sign;
  logic       i_E;
  logic       i_ERR;

  logic [2:0] o_ALUOp;
  logic [1:0] o_sel_srcA;
  logic [1:0] o_sel_srcB;
  logic [1:0] o_sel_r0;
  logic [1:0] o_sel_r1;
  logic       o_en_r0;
  logic       o_en_r1;
  logic       o_rst_r0;
  logic       o_rst_r1;
  logic       o_lft_rght_q;
  logic       o_ser_par_q;
  logic       o_rst_q;
  logic       o_rst_acc;
  logic       o_shft_sel;
  logic       o_r0_r1_sel;
  logic       o_err_upd;
  logic       o_e_upd;
  logic       o_rst_err_e;
  logic       o_busy;
  logic       o_done;

  modport slave (
    input  i_start, i_op, i_Q0, i_acc_sign, i_r0_sign, i_r1_sign, i_E, i_ERR,
    output o_ALUOp, o_sel_srcA, o_sel_srcB, o_sel_r0, o_sel_r1,
           o_en_r0, o_en_r1, o_rst_r0, o_rst_r1,
           o_lft_rght_q, o_ser_par_q, o_rst_q, o_rst_acc, o_shft_sel, o_r0_r1_sel,
           o_err_upd, o_e_upd, o_rst_err_e, o_busy, o_done
  );

  modport master (
    output i_start, i_op, i_Q0, i_acc_sign, i_r0_sign, i_r1_sign, i_E, i_ERR,
    input  o_ALUOp, o_sel_srcA, o_sel_srcB, o_sel_r0, o_sel_r1,
           o_en_r0, o_en_r1, o_rst_r0, o_rst_r1,
           o_lft_rght_q, o_ser_par_q, o_rst_q, o_rst_acc, o_shft_sel, o_r0_r1_sel,
           o_err_upd, o_e_upd, o_rst_err_e, o_busy, o_done
  );
endinterface

// File: rtl/alp_controller.sv
// ALP controller: latches an opcode on start, then sequences the datapath
// control lines. Single-cycle ops use one EXEC cycle; unsigned multiply is a
// shift-add loop of WIDTH add/shift pairs followed by a writeback of ACC:Q.
// All control lines come from registers decoded from the next state, except
// the multiply-add B select, which must follow the live Q LSB.
module alp_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic clr_n,
  alp_controller_if.slave bus
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_NEG0 = 3'b001;
  localparam logic [2:0] OP_NEG1 = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL_INIT,
    MUL_ADD,
    MUL_SHIFT,
    MUL_WB,
    DONE
  } state_t;

  typedef struct packed {
    logic [2:0] aluOp;
    logic [1:0] selSrcA;
    logic [1:0] selSrcB;
    logic [1:0] selR0;
    logic [1:0] selR1;
    logic       enR0;
    logic       enR1;
    logic       rstR0;
    logic       rstR1;
    logic       lftRghtQ;
    logic       serParQ;
    logic       rstQ;
    logic       rstAcc;
    logic       shftSel;
    logic       r0R1Sel;
    logic       errUpd;
    logic       eUpd;
    logic       rstErrE;
    logic       busy;
    logic       done;
    logic       mulAdd;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             unusedStatus;

  // Sign/E/ERR flags are reserved inputs in this revision.
  assign unusedStatus = ^{bus.i_acc_sign, bus.i_r0_sign, bus.i_r1_sign, bus.i_E, bus.i_ERR};

  // Next-state, opcode latch and iteration counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          op_d    = bus.i_op;
          state_d = (bus.i_op == OP_MUL) ? MUL_INIT : EXEC;
        end
      end
      EXEC:     state_d = DONE;
      MUL_INIT: begin
        cnt_d   = '0;
        state_d = MUL_ADD;
      end
      MUL_ADD:  state_d = MUL_SHIFT;
      MUL_SHIFT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST_ITER) ? MUL_WB : MUL_ADD;
      end
      MUL_WB:   state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Control-line decode of the state being entered, so outputs can be registered.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      EXEC: begin
        case (op_d)
          OP_LOAD: begin
            ctrl_d.selR0 = 2'b10;
            ctrl_d.selR1 = 2'b10;
            ctrl_d.enR0  = 1'b1;
            ctrl_d.enR1  = 1'b1;
          end
          OP_NEG0: begin
            ctrl_d.selSrcA = 2'b01;
            ctrl_d.aluOp   = 3'b010;
            ctrl_d.enR0    = 1'b1;
          end
          OP_NEG1: begin
            ctrl_d.selSrcB = 2'b01;
            ctrl_d.aluOp   = 3'b001;
            ctrl_d.enR1    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl_d.selSrcA = 2'b01;
            ctrl_d.selSrcB = 2'b01;
            ctrl_d.aluOp   = (op_d == OP_SUB) ? 3'b001 : 3'b000;
            ctrl_d.enR0    = 1'b1;
            ctrl_d.errUpd  = 1'b1;
            ctrl_d.eUpd    = 1'b1;
          end
          OP_CLR: begin
            ctrl_d.rstR0   = 1'b1;
            ctrl_d.rstR1   = 1'b1;
            ctrl_d.rstQ    = 1'b1;
            ctrl_d.rstAcc  = 1'b1;
            ctrl_d.rstErrE = 1'b1;
          end
          OP_RSVD: ctrl_d.errUpd = 1'b1;
          default: ;
        endcase
      end
      MUL_INIT: begin
        ctrl_d.rstAcc  = 1'b1;
        ctrl_d.serParQ = 1'b1;
        ctrl_d.rstErrE = 1'b1;
      end
      MUL_ADD: begin
        ctrl_d.selSrcA = 2'b11;
        ctrl_d.mulAdd  = 1'b1;
      end
      MUL_SHIFT: begin
        ctrl_d.shftSel  = 1'b1;
        ctrl_d.lftRghtQ = 1'b1;
      end
      MUL_WB: begin
        ctrl_d.selR0 = 2'b01;
        ctrl_d.selR1 = 2'b01;
        ctrl_d.enR0  = 1'b1;
        ctrl_d.enR1  = 1'b1;
      end
      DONE:    ctrl_d.done = 1'b1;
      default: ;
    endcase
    ctrl_d.busy = (state_d != IDLE) && (state_d != DONE);
  end

  // State, opcode, counter and control-line registers; reset aborts any op.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.o_ALUOp      = ctrl_q.aluOp;
  assign bus.o_sel_srcA   = ctrl_q.selSrcA;
  assign bus.o_sel_srcB   = ctrl_q.selSrcB | {1'b0, ctrl_q.mulAdd & bus.i_Q0};
  assign bus.o_sel_r0     = ctrl_q.selR0;
  assign bus.o_sel_r1     = ctrl_q.selR1;
  assign bus.o_en_r0      = ctrl_q.enR0;
  assign bus.o_en_r1      = ctrl_q.enR1;
  assign bus.o_rst_r0     = ctrl_q.rstR0;
  assign bus.o_rst_r1     = ctrl_q.rstR1;
  assign bus.o_lft_rght_q = ctrl_q.lftRghtQ;
  assign bus.o_ser_par_q  = ctrl_q.serParQ;
  assign bus.o_rst_q      = ctrl_q.rstQ;
  assign bus.o_rst_acc    = ctrl_q.rstAcc;
  assign bus.o_shft_sel   = ctrl_q.shftSel;
  assign bus.o_r0_r1_sel  = ctrl_q.r0R1Sel;
  assign bus.o_err_upd    = ctrl_q.errUpd;
  assign bus.o_e_upd      = ctrl_q.eUpd;
  assign bus.o_rst_err_e  = ctrl_q.rstErrE;
  assign bus.o_busy       = ctrl_q.busy;
  assign bus.o_done       = ctrl_q.done;

endmodule

// File: tb/tb_alp_controller.sv
// Bench for alp_controller: a small behavioural 4-bit datapath (R0, R1,
// ACC with carry, Q) is driven by the controller; expected register contents
// and latencies are queued when an op starts and compared on o_done.
module tb_alp_controller;
  localparam int WIDTH      = 4;
  localparam int CNT_W      = 2;
  localparam int DONE_BOUND = 40;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_NEG0 = 3'b001;
  localparam logic [2:0] OP_NEG1 = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef struct {
    logic [3:0] r1;
    logic [3:0] r0;
    int         lat;
    int         startCyc;
  } exp_t;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  int total = 0;
  int bad   = 0;
  int cycleCnt  = 0;
  int busyCnt   = 0;
  int shiftCnt  = 0;
  int errUpdCnt = 0;
  int enCnt     = 0;

  exp_t sbQ[$];

  logic [3:0]  r0, r1, q, dataIn;
  logic [4:0]  acc;
  logic [3:0]  aVal, bVal;
  logic [4:0]  aluRes;
  logic [25:0] allOuts;

  alp_controller_if bif();

  alp_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  assign bif.i_Q0       = q[0];
  assign bif.i_acc_sign = acc[3];
  assign bif.i_r0_sign  = r0[3];
  assign bif.i_r1_sign  = r1[3];
  assign bif.i_E        = 1'b0;
  assign bif.i_ERR      = 1'b0;

  assign allOuts = {bif.o_ALUOp, bif.o_sel_srcA, bif.o_sel_srcB, bif.o_sel_r0, bif.o_sel_r1,
                    bif.o_en_r0, bif.o_en_r1, bif.o_rst_r0, bif.o_rst_r1,
                    bif.o_lft_rght_q, bif.o_ser_par_q, bif.o_rst_q, bif.o_rst_acc,
                    bif.o_shft_sel, bif.o_r0_r1_sel, bif.o_err_upd, bif.o_e_upd,
                    bif.o_rst_err_e, bif.o_busy, bif.o_done};

  // Datapath operand muxes and ALU.
  always_comb begin
    case (bif.o_sel_srcA)
      2'b00:   aVal = '0;
      2'b01:   aVal = r0;
      2'b10:   aVal = r1;
      default: aVal = acc[3:0];
    endcase
    case (bif.o_sel_srcB)
      2'b00:   bVal = '0;
      2'b01:   bVal = r1;
      2'b10:   bVal = r0;
      default: bVal = acc[3:0];
    endcase
    case (bif.o_ALUOp)
      3'b000:  aluRes = {1'b0, aVal} + {1'b0, bVal};
      3'b001:  aluRes = {1'b0, aVal} - {1'b0, bVal};
      3'b010:  aluRes = {1'b0, bVal} - {1'b0, aVal};
      default: aluRes = '0;
    endcase
  end

  // Datapath registers reacting to the controller's control lines.
  always @(posedge clk) begin
    if (bif.o_rst_r0) r0 <= '0;
    else if (bif.o_en_r0)
      case (bif.o_sel_r0)
        2'b00:   r0 <= aluRes[3:0];
        2'b01:   r0 <= q;
        2'b10:   r0 <= dataIn;
        default: r0 <= r0;
      endcase
    if (bif.o_rst_r1) r1 <= '0;
    else if (bif.o_en_r1)
      case (bif.o_sel_r1)
        2'b00:   r1 <= aluRes[3:0];
        2'b01:   r1 <= acc[3:0];
        2'b10:   r1 <= r0;
        default: r1 <= r1;
      endcase
    if (bif.o_rst_acc)       acc <= '0;
    else if (bif.o_shft_sel) acc <= {1'b0, acc[4:1]};
    else                     acc <= aluRes;
    if (bif.o_rst_q)           q <= '0;
    else if (bif.o_ser_par_q)  q <= bif.o_r0_r1_sel ? r1 : r0;
    else if (bif.o_lft_rght_q) q <= {acc[0], q[3:1]};
  end

  // Cycle and activity counters, sampling the values held during each cycle.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (bif.o_busy)                 busyCnt   <= busyCnt + 1;
    if (bif.o_shft_sel)             shiftCnt  <= shiftCnt + 1;
    if (bif.o_err_upd)              errUpdCnt <= errUpdCnt + 1;
    if (bif.o_en_r0 || bif.o_en_r1) enCnt     <= enCnt + 1;
  end

  task automatic issueOp(input logic [2:0] op, input logic [3:0] din,
                         input logic [3:0] expR1, input logic [3:0] expR0, input int lat);
    exp_t e;
    @(negedge clk);
    dataIn      = din;
    bif.i_op    = op;
    bif.i_start = 1'b1;
    e.r1 = expR1;
    e.r0 = expR0;
    e.lat = lat;
    e.startCyc = cycleCnt;
    sbQ.push_back(e);
    @(negedge clk);
    bif.i_start = 1'b0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < DONE_BOUND; i++) begin
      if (bif.o_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic preloadRegs(input logic [3:0] r0Val, input logic [3:0] r1Val);
    bit ok;
    issueOp(OP_LOAD, r1Val, 4'h0, 4'h0, 2);
    waitDone(ok);
    issueOp(OP_LOAD, r0Val, 4'h0, 4'h0, 2);
    waitDone(ok);
    sbQ.delete();
  endtask

  task automatic test_reset();
    bit ok;
    exp_t e;
    @(negedge clk);
    total++;
    if (allOuts !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", allOuts);
    end
    @(negedge clk);
    clr_n = 1'b1;
    issueOp(OP_CLR, 4'h0, 4'h0, 4'h0, 2);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++; sbQ.delete();
      $display("FAIL clr_done got=timeout want=done");
    end else begin
      e = sbQ.pop_front();
      total++;
      if ({r1, r0} !== {e.r1, e.r0}) begin
        bad++; $display("FAIL clr_regs got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
      end
      total++;
      if (cycleCnt - e.startCyc != e.lat) begin
        bad++; $display("FAIL clr_latency got=%0d want=%0d", cycleCnt - e.startCyc, e.lat);
      end
    end
  endtask

  task automatic test_load();
    bit ok;
    exp_t e;
    logic [3:0] vals [2];
    logic [3:0] expR1 [2];
    vals  = '{4'b0110, 4'b1001};
    expR1 = '{4'b0000, 4'b0110};
    for (int i = 0; i < 2; i++) begin
      issueOp(OP_LOAD, vals[i], expR1[i], vals[i], 2);
      waitDone(ok);
      total++;
      if (!ok) begin
        bad++; sbQ.delete();
        $display("FAIL load_done got=timeout want=done");
      end else begin
        e = sbQ.pop_front();
        total++;
        if ({r1, r0} !== {e.r1, e.r0}) begin
          bad++; $display("FAIL load_regs got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
        end
        total++;
        if (cycleCnt - e.startCyc != e.lat) begin
          bad++; $display("FAIL load_latency got=%0d want=%0d", cycleCnt - e.startCyc, e.lat);
        end
      end
    end
  endtask

  task automatic test_neg();
    bit ok;
    exp_t e;
    logic [2:0] ops [4];
    logic [7:0] exps [4];
    ops  = '{OP_NEG0, OP_NEG1, OP_NEG0, OP_NEG1};
    exps = '{8'b0110_0111, 8'b1010_0111, 8'b1010_1001, 8'b0110_1001};
    for (int i = 0; i < 4; i++) begin
      issueOp(ops[i], 4'h0, exps[i][7:4], exps[i][3:0], 2);
      waitDone(ok);
      total++;
      if (!ok) begin
        bad++; sbQ.delete();
        $display("FAIL neg_done got=timeout want=done");
      end else begin
        e = sbQ.pop_front();
        total++;
        if ({r1, r0} !== {e.r1, e.r0}) begin
          bad++; $display("FAIL neg_regs step=%0d got=%b_%b want=%b_%b", i, r1, r0, e.r1, e.r0);
        end
      end
    end
  endtask

  task automatic test_add_sub();
    bit ok;
    exp_t e;
    logic [2:0] ops [2];
    logic [7:0] exps [2];
    ops  = '{OP_ADD, OP_SUB};
    exps = '{8'b0110_1111, 8'b0110_1001};
    for (int i = 0; i < 2; i++) begin
      issueOp(ops[i], 4'h0, exps[i][7:4], exps[i][3:0], 2);
      waitDone(ok);
      total++;
      if (!ok) begin
        bad++; sbQ.delete();
        $display("FAIL addsub_done got=timeout want=done");
      end else begin
        e = sbQ.pop_front();
        total++;
        if ({r1, r0} !== {e.r1, e.r0}) begin
          bad++; $display("FAIL addsub_regs step=%0d got=%b_%b want=%b_%b", i, r1, r0, e.r1, e.r0);
        end
      end
    end
  endtask

  task automatic test_mul();
    bit ok;
    exp_t e;
    int busy0, shift0;
    preloadRegs(4'b0011, 4'b0101);
    busy0  = busyCnt;
    shift0 = shiftCnt;
    issueOp(OP_MUL, 4'h0, 4'b0000, 4'b1111, 11);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++; sbQ.delete();
      $display("FAIL mul_done got=timeout want=done");
    end else begin
      e = sbQ.pop_front();
      total++;
      if ({r1, r0} !== {e.r1, e.r0}) begin
        bad++; $display("FAIL mul_product got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
      end
      total++;
      if (cycleCnt - e.startCyc != e.lat) begin
        bad++; $display("FAIL mul_latency got=%0d want=%0d", cycleCnt - e.startCyc, e.lat);
      end
      total++;
      if (busyCnt - busy0 != 10) begin
        bad++; $display("FAIL mul_busy_cycles got=%0d want=10", busyCnt - busy0);
      end
      total++;
      if (shiftCnt - shift0 != 4) begin
        bad++; $display("FAIL mul_shift_count got=%0d want=4", shiftCnt - shift0);
      end
    end
  endtask

  task automatic test_mul_ignore_start();
    bit ok;
    exp_t e;
    int en0, startCyc;
    preloadRegs(4'b1111, 4'b1111);
    en0 = enCnt;
    issueOp(OP_MUL, 4'b1010, 4'b1110, 4'b0001, 11);
    startCyc = sbQ[0].startCyc;
    for (int i = 0; i < 10 && cycleCnt < startCyc + 5; i++) @(negedge clk);
    bif.i_op    = OP_LOAD;
    bif.i_start = 1'b1;
    @(negedge clk);
    bif.i_start = 1'b0;
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++; sbQ.delete();
      $display("FAIL mulign_done got=timeout want=done");
    end else begin
      e = sbQ.pop_front();
      total++;
      if ({r1, r0} !== {e.r1, e.r0}) begin
        bad++; $display("FAIL mulign_product got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
      end
      total++;
      if (cycleCnt - e.startCyc != e.lat) begin
        bad++; $display("FAIL mulign_latency got=%0d want=%0d", cycleCnt - e.startCyc, e.lat);
      end
      total++;
      if (enCnt - en0 != 1) begin
        bad++; $display("FAIL mulign_writes got=%0d want=1", enCnt - en0);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    exp_t e;
    int startCyc;
    preloadRegs(4'b0011, 4'b0101);
    issueOp(OP_MUL, 4'h0, 4'h0, 4'h0, 11);
    startCyc = sbQ[0].startCyc;
    for (int i = 0; i < 10 && cycleCnt < startCyc + 4; i++) @(negedge clk);
    total++;
    if (bif.o_sel_srcA !== 2'b11 || bif.o_shft_sel !== 1'b0 || bif.o_busy !== 1'b1) begin
      bad++; $display("FAIL abort_in_mul_add got=srcA%b_shft%b_busy%b want=srcA11_shft0_busy1",
                      bif.o_sel_srcA, bif.o_shft_sel, bif.o_busy);
    end
    clr_n = 1'b0;
    #1;
    sbQ.delete();
    total++;
    if (allOuts !== '0) begin
      bad++; $display("FAIL abort_outputs got=%b want=0", allOuts);
    end
    total++;
    if (bif.o_busy !== 1'b0) begin
      bad++; $display("FAIL abort_busy got=%b want=0", bif.o_busy);
    end
    @(negedge clk);
    total++;
    if ({r1, r0} !== 8'b0101_0011) begin
      bad++; $display("FAIL abort_no_writeback got=%b_%b want=0101_0011", r1, r0);
    end
    clr_n = 1'b1;
    issueOp(OP_LOAD, 4'b1100, 4'b0011, 4'b1100, 2);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++; sbQ.delete();
      $display("FAIL abort_load_done got=timeout want=done");
    end else begin
      e = sbQ.pop_front();
      total++;
      if ({r1, r0} !== {e.r1, e.r0}) begin
        bad++; $display("FAIL abort_load_regs got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
      end
      total++;
      if (cycleCnt - e.startCyc != e.lat) begin
        bad++; $display("FAIL abort_load_latency got=%0d want=%0d", cycleCnt - e.startCyc, e.lat);
      end
    end
  endtask

  task automatic test_reserved();
    bit ok;
    exp_t e;
    int err0, en0;
    err0 = errUpdCnt;
    en0  = enCnt;
    issueOp(OP_RSVD, 4'b0110, 4'b0011, 4'b1100, 2);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++; sbQ.delete();
      $display("FAIL rsvd_done got=timeout want=done");
    end else begin
      e = sbQ.pop_front();
      total++;
      if ({r1, r0} !== {e.r1, e.r0}) begin
        bad++; $display("FAIL rsvd_regs got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
      end
      total++;
      if (cycleCnt - e.startCyc != e.lat) begin
        bad++; $display("FAIL rsvd_latency got=%0d want=%0d", cycleCnt - e.startCyc, e.lat);
      end
      total++;
      if (errUpdCnt - err0 != 1) begin
        bad++; $display("FAIL rsvd_err_upd got=%0d want=1", errUpdCnt - err0);
      end
      total++;
      if (enCnt - en0 != 0) begin
        bad++; $display("FAIL rsvd_writes got=%0d want=0", enCnt - en0);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit sawDone;
    exp_t e;
    issueOp(OP_LOAD, 4'b0111, 4'b1100, 4'b0111, 2);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++; sbQ.delete();
      $display("FAIL b2b_done got=timeout want=done");
    end else begin
      bif.i_op    = OP_LOAD;
      dataIn      = 4'b0001;
      bif.i_start = 1'b1;
      e = sbQ.pop_front();
      total++;
      if ({r1, r0} !== {e.r1, e.r0}) begin
        bad++; $display("FAIL b2b_regs got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
      end
      @(negedge clk);
      bif.i_start = 1'b0;
      total++;
      if (bif.o_done !== 1'b0 || bif.o_busy !== 1'b0) begin
        bad++; $display("FAIL b2b_start_in_done got=done%b_busy%b want=done0_busy0",
                        bif.o_done, bif.o_busy);
      end
      sawDone = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (bif.o_done) sawDone = 1'b1;
      end
      total++;
      if (sawDone || {r1, r0} !== 8'b1100_0111) begin
        bad++; $display("FAIL b2b_ignored got=done%b_%b_%b want=done0_1100_0111", sawDone, r1, r0);
      end
    end
    issueOp(OP_NEG0, 4'h0, 4'b1100, 4'b1001, 2);
    waitDone(ok);
    total++;
    if (!ok) begin
      bad++; sbQ.delete();
      $display("FAIL b2b_next_done got=timeout want=done");
    end else begin
      e = sbQ.pop_front();
      total++;
      if ({r1, r0} !== {e.r1, e.r0}) begin
        bad++; $display("FAIL b2b_next_regs got=%b_%b want=%b_%b", r1, r0, e.r1, e.r0);
      end
      total++;
      if (cycleCnt - e.startCyc != e.lat) begin
        bad++; $display("FAIL b2b_next_latency got=%0d want=%0d", cycleCnt - e.startCyc, e.lat);
      end
    end
  endtask

  initial begin
    bif.i_start = 1'b0;
    bif.i_op    = 3'b000;
    dataIn      = 4'h0;
    test_reset();
    test_load();
    test_neg();
    test_add_sub();
    test_mul();
    test_mul_ignore_start();
    test_abort();
    test_reserved();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
